// File: rtl/mc_control_pkg.sv
// Shared definitions for the 16-bit multi-cycle processor: opcodes, ALU ops,
// FSM states, instruction classes and datapath mux select codes.
package proc_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b0111;
  localparam logic [3:0] OP_J     = 4'b1000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsR, ClsLw, ClsSw, ClsBeq, ClsAddi, ClsJ, ClsIll
  } op_class_e;

  // An R-type with an unsupported funct is as illegal as an unknown opcode.
  function automatic op_class_e decode_class(logic [3:0] opcode, logic funct_valid);
    op_class_e cls;
    case (opcode)
      OP_RTYPE: cls = funct_valid ? ClsR : ClsIll;
      OP_LW:    cls = ClsLw;
      OP_SW:    cls = ClsSw;
      OP_BEQ:   cls = ClsBeq;
      OP_ADDI:  cls = ClsAddi;
      OP_J:     cls = ClsJ;
      default:  cls = ClsIll;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control/datapath bundle between mc_control (master) and the datapath (slave).
interface mc_control_if;
  logic [15:0] instr;
  logic        mem_ready;
  logic        zero;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        retired;
  logic        illegal;
  logic        timeout;
  logic [2:0]  state;

  modport master (
    input  instr, mem_ready, zero,
    output alu_op, alu_src_a, alu_src_b, pc_en, pc_src, ir_write, mem_read, mem_write,
           i_or_d, reg_write, reg_dst, mem_to_reg, retired, illegal, timeout, state
  );

  modport slave (
    output instr, mem_ready, zero,
    input  alu_op, alu_src_a, alu_src_b, pc_en, pc_src, ir_write, mem_read, mem_write,
           i_or_d, reg_write, reg_dst, mem_to_reg, retired, illegal, timeout, state
  );
endinterface

// File: rtl/mc_control_alu_op_decode.sv
// R-type funct to ALU operation decode; flags functs the ALU does not implement.
module alu_op_decode
  import proc_pkg::*;
(
  input  logic [2:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_funct_valid
);

  always_comb begin
    o_alu_op      = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_funct)
      3'b000:  o_alu_op = ALU_AND;
      3'b001:  o_alu_op = ALU_OR;
      3'b010:  o_alu_op = ALU_ADD;
      3'b110:  o_alu_op = ALU_SUB;
      default: o_funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM (fetch/decode/execute/memory/writeback) for the 16-bit processor.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions halt the FSM instead of acting as NOPs.
module mc_control
  import proc_pkg::*;
#(
  parameter int unsigned IMEM_WAIT_MAX = 15
) (
  input logic          clk,
  input logic          rst,
  mc_control_if.master bus
);

  localparam logic [3:0] WaitMax = 4'(IMEM_WAIT_MAX);

  state_e    r_state, w_state_next;
  op_class_e r_op_class, w_class;
  logic [3:0] r_wait_cnt, w_wait_inc;
  logic       r_timeout;
  logic [2:0] w_funct_op;
  logic       w_funct_valid;
  logic       w_waiting;
  logic       w_unused_instr;

  assign w_unused_instr = ^bus.instr[11:3];

  alu_op_decode u_alu_op_decode (
    .i_funct      (bus.instr[2:0]),
    .o_alu_op     (w_funct_op),
    .o_funct_valid(w_funct_valid)
  );

  assign w_class    = decode_class(bus.instr[15:12], w_funct_valid);
  assign w_waiting  = ((r_state == StFetch) || (r_state == StMem)) && !bus.mem_ready;
  assign w_wait_inc = (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StFetch;
      r_op_class <= ClsR;
      r_wait_cnt <= 4'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StDecode) r_op_class <= w_class;
      r_wait_cnt <= w_waiting ? w_wait_inc : 4'd0;
      if (w_waiting && (WaitMax != 4'd0) && (w_wait_inc >= WaitMax)) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:  if (bus.mem_ready) w_state_next = StDecode;
      StDecode: begin
        if (w_class == ClsJ) begin
          w_state_next = StFetch;
        end else if (w_class == ClsIll) begin
`ifdef ILLEGAL_TRAP_EN
          w_state_next = StHalt;
`else
          w_state_next = StFetch;
`endif
        end else begin
          w_state_next = StExec;
        end
      end
      StExec: begin
        case (r_op_class)
          ClsR, ClsAddi: w_state_next = StWb;
          ClsLw, ClsSw:  w_state_next = StMem;
          default:       w_state_next = StFetch;
        endcase
      end
      StMem:   if (bus.mem_ready) w_state_next = (r_op_class == ClsLw) ? StWb : StFetch;
      StWb:    w_state_next = StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  // Reset forces every output low, including the debug state and sticky timeout.
  always_comb begin
    bus.alu_op     = 3'b000;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.pc_en      = 1'b0;
    bus.pc_src     = PC_ALU;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.retired    = 1'b0;
    bus.illegal    = 1'b0;
    bus.timeout    = 1'b0;
    bus.state      = 3'd0;
    if (!rst) begin
      bus.state   = r_state;
      bus.timeout = r_timeout;
      case (r_state)
        StFetch: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_ONE;
          bus.alu_op    = ALU_ADD;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_en    = 1'b1;
          end
        end
        StDecode: begin
          bus.alu_src_b = SRCB_BR;
          bus.alu_op    = ALU_ADD;
          if (w_class == ClsJ) begin
            bus.pc_en   = 1'b1;
            bus.pc_src  = PC_JUMP;
            bus.retired = 1'b1;
          end
          bus.illegal = (w_class == ClsIll);
        end
        StExec: begin
          bus.alu_src_a = 1'b1;
          case (r_op_class)
            ClsR: bus.alu_op = w_funct_op;
            ClsLw, ClsSw, ClsAddi: begin
              bus.alu_src_b = SRCB_IMM;
              bus.alu_op    = ALU_ADD;
            end
            ClsBeq: begin
              bus.alu_op  = ALU_SUB;
              bus.pc_src  = PC_ALUOUT;
              bus.pc_en   = bus.zero;
              bus.retired = 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = (r_op_class == ClsLw);
          bus.mem_write = (r_op_class == ClsSw);
          bus.retired   = bus.mem_ready && (r_op_class == ClsSw);
        end
        StWb: begin
          bus.reg_write  = 1'b1;
          bus.retired    = 1'b1;
          bus.reg_dst    = (r_op_class == ClsR);
          bus.mem_to_reg = (r_op_class == ClsLw);
        end
        default: ;
      endcase
    end
  end

endmodule
